// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: shares one signed booth multiplier between N_REQ
// requesters. A round-robin grant loads the operands, pulses the booth
// active-low start, waits for done (bounded by MAX_CYC) and returns the
// product, or a timeout error, through a per-requester response handshake.
module booth_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 4,
  parameter int MAX_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   resp_valid,
  input  logic [N_REQ-1:0]   resp_ready,
  output logic [2*W-1:0]     resp_data,
  output logic               resp_err,
  output logic               busy,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  output logic               mul_rstN,
  input  logic [2*W-1:0]     mul_res,
  input  logic               mul_done
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYC - 1);
  localparam logic [PW-1:0] PTR_INIT = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [PW-1:0]      ptr_r;
  logic [PW-1:0]      gnt_r;
  logic [CW-1:0]      cnt_r;
  logic [W-1:0]       mul_a_r;
  logic [W-1:0]       mul_b_r;
  logic               mul_rstn_r;
  logic [N_REQ-1:0]   resp_valid_r;
  logic [2*W-1:0]     resp_data_r;
  logic               resp_err_r;
  logic               busy_r;

  logic [PW-1:0]      gnt_idx_s;
  logic               any_req_s;
  logic [N_REQ-1:0]   req_ready_s;
  logic               run_done_s;
  logic               run_tmo_s;
  logic               resp_acc_s;

  // Decode a requester index into its one-hot lane.
  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: scan downward so the nearest requester after ptr wins.
  always_comb begin
    gnt_idx_s = '0;
    any_req_s = |req_valid;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      gnt_idx_s = req_valid[(int'(ptr_r) + 1 + k) % N_REQ] ?
                  PW'((int'(ptr_r) + 1 + k) % N_REQ) : gnt_idx_s;
    end
  end

  // Accept pulse is combinational so the requester sees it in the grant cycle.
  always_comb begin
    req_ready_s = '0;
    if ((state_r == ST_IDLE) && any_req_s) begin
      req_ready_s = onehot(gnt_idx_s);
    end else begin
      req_ready_s = '0;
    end
  end

  // RUN exit conditions; the first RUN cycle ignores a stale done from the
  // previous operation, and a real done beats a coincident timeout.
  always_comb begin
    run_done_s = (state_r == ST_RUN) && (cnt_r != '0) && mul_done;
    run_tmo_s  = (state_r == ST_RUN) && !run_done_s && (cnt_r == CNT_LAST);
    resp_acc_s = (state_r == ST_RESP) && resp_ready[gnt_r];
  end

  // Next-state decode for the transaction sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (run_done_s || run_tmo_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RESP: begin
        if (resp_acc_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: operand capture, booth start pulse, cycle counter, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r        <= PTR_INIT;
      gnt_r        <= '0;
      cnt_r        <= '0;
      mul_a_r      <= '0;
      mul_b_r      <= '0;
      mul_rstn_r   <= 1'b1;
      resp_valid_r <= '0;
      resp_data_r  <= '0;
      resp_err_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            mul_a_r    <= req_a[gnt_idx_s*W +: W];
            mul_b_r    <= req_b[gnt_idx_s*W +: W];
            ptr_r      <= gnt_idx_s;
            gnt_r      <= gnt_idx_s;
            mul_rstn_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          cnt_r      <= '0;
          mul_rstn_r <= 1'b1;
        end
        ST_RUN: begin
          if (run_done_s) begin
            resp_data_r  <= mul_res;
            resp_err_r   <= 1'b0;
            resp_valid_r <= onehot(gnt_r);
          end else if (run_tmo_s) begin
            resp_data_r  <= '0;
            resp_err_r   <= 1'b1;
            resp_valid_r <= onehot(gnt_r);
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_RESP: begin
          if (resp_acc_s) begin
            resp_valid_r <= '0;
          end
        end
        default: begin
          resp_valid_r <= '0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_err   = resp_err_r;
  assign busy       = busy_r;
  assign mul_a      = mul_a_r;
  assign mul_b      = mul_b_r;
  assign mul_rstN   = mul_rstn_r;

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Shares one 4-bit signed booth multiplier between N_REQ requesters.
- Requesters submit operand pairs through a valid/ready handshake.
- A round-robin arbiter grants one request at a time. The block loads the operands, pulses the multiplier's active-low start/reset, waits for done (with timeout), and returns the product to the granted requester through a response handshake.
- Sits between the client datapaths and the single booth instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- W, 4, operand width; product width is 2*W
- MAX_CYC, 16, cycles allowed in RUN before a timeout error

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  N_REQ  per-requester request valid
- req_a  in  N_REQ*W  signed operand A; requester i uses bits [i*W +: W]
- req_b  in  N_REQ*W  signed operand B, same packing as req_a
- req_ready  out  N_REQ  one-hot accept pulse
- resp_valid  out  N_REQ  one-hot response valid, held until accepted
- resp_ready  in  N_REQ  per-requester response accept
- resp_data  out  2*W  signed product (shared bus)
- resp_err  out  1  1 = timeout; resp_data is 0 when set
- busy  out  1  1 whenever state != IDLE
- mul_a  out  W  operand A to booth, registered
- mul_b  out  W  operand B to booth, registered
- mul_rstN  out  1  active-low start/reset to booth
- mul_res  in  2*W  booth product
- mul_done  in  1  booth completion flag

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; req_ready=0, resp_valid=0, resp_data=0, resp_err=0, busy=0.
  - mul_a=0, mul_b=0, mul_rstN=1.
  - RR pointer=N_REQ-1, so requester 0 has first priority; cycle counter=0.
  - rst overrides everything, including mid-operation. An in-flight request is dropped with no response. mul_rstN returns to 1.
- IDLE:
  - If any req_valid is set, grant g = first requester with req_valid set, searching from pointer+1 modulo N_REQ.
  - Same cycle: req_ready[g]=1 for exactly one cycle (combinational from state and req_valid).
  - Next edge: latch mul_a/mul_b from slot g; pointer=g; go LOAD.
  - If no req_valid: stay in IDLE; all outputs held.
- LOAD (1 cycle): mul_rstN=0; counter=0; next RUN.
- RUN:
  - mul_rstN=1.
  - First RUN cycle is a guard cycle: mul_done is ignored, since a stale done from the previous op may still be visible.
  - From the second cycle on, mul_done=1 → latch resp_data=mul_res, resp_err=0; go RESP.
  - counter increments each RUN cycle. If counter reaches MAX_CYC-1 without done → resp_data=0, resp_err=1; go RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - resp_valid[g]=1; resp_data and resp_err stable.
  - When resp_ready[g]=1 → resp_valid=0 next edge; go IDLE.
  - resp_ready from other requesters is ignored.
  - Back-to-back: an IDLE grant can happen on the cycle after RESP completes.
- Latency: accept to resp_valid = 1 (LOAD) + 1 (guard) + booth cycles + 1 register.
- Requests change only when granted. A requester deasserting req_valid while not granted loses no data.
- Fairness: any requester holding req_valid is granted within N_REQ transactions.
- Operands and products are two's complement. No saturation; the 2W-bit product covers the full range, e.g. -8*-8 = 64.

Test Plan:
- Single request: requester 0 sends A=-7, B=-5 → req_ready[0] pulses one cycle; mul_rstN low exactly one cycle; resp_valid[0] with resp_data=35 (8'b00100011), resp_err=0.
- Round robin: requesters 0..3 all valid with (7,-6), (-4,3), (-8,-8), (5,5) → grants in order 0,1,2,3; results -42, -12, 64, 25 on the matching resp_valid bits.
- Fairness after grant: requester 1 served last; requesters 0 and 1 both valid → 0 is granted before 1 re-wins.
- Response backpressure: resp_ready[2] held low 5 cycles → resp_valid[2] and resp_data stay stable; no new grant occurs; releasing it returns to IDLE.
- Timeout: booth model with mul_done tied 0, MAX_CYC=16 → resp_err=1, resp_data=0 after 16 RUN cycles; next request is served normally.
- Reset mid-RUN: assert rst for 1 cycle during RUN → all outputs at reset values next cycle; no response for the dropped request; pointer=N_REQ-1; a subsequent request from requester 0 is granted first.
